gcd_job_sched: RTL and testbench
================================

# gcd_job_sched

Avalon-MM master that shares one `gcd_avalon` slave between `NREQ` requesters. It round-robin arbitrates pending jobs and programs operands A and B. It then polls the status register until done, reads the result and returns it to the owning requester. The block sits between requester logic and the `gcd_avalon` register port, and is the only master on that port.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `POLL_MAX`, 1024: maximum status polls per job before timeout.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `req_valid` in NREQ: job pending, one bit per requester.
- `req_ready` out NREQ: job accepted this cycle, one-hot or zero.
- `req_a` in NREQ*32: operand A; requester i occupies bits [32i+31:32i].
- `req_b` in NREQ*32: operand B, same packing as `req_a`.
- `rsp_valid` out NREQ: result available, one-hot or zero.
- `rsp_ready` in NREQ: requester takes the result.
- `rsp_data` out 32: GCD result, shared by all requesters and valid for the bit set in `rsp_valid`.
- `rsp_err` out 1: poll timeout; `rsp_data` is 0 when set.
- `av_address` out 2: slave register address.
- `av_write` out 1: write strobe.
- `av_read` out 1: read strobe.
- `av_writedata` out 32: write data.
- `av_readdata` in 32: read data, valid the cycle after `av_read`; fixed read latency 1, no waitrequest.
- `av_byteenable` out 4: constant 4'hF.
- `av_chipselect` out 1: high exactly when `av_read` or `av_write` is high.

## Operation
- Slave map:
  - 0: A (write).
  - 1: B (write).
  - 2: result (read).
  - 3: status (read); bit0 is done.
- FSM states: IDLE, WR_A, WR_B, POLL_RD, POLL_CHK, RES_RD, RES_CAP, RESP.
- IDLE:
  - If any `req_valid` is high, the arbiter grants requester g and `req_ready[g]`=1 for one cycle.
  - On that cycle the block latches `req_a[g]`, `req_b[g]` and the grant id g, and moves to WR_A.
- WR_A drives `av_write`=1, address 0, data A. WR_B does the same with address 1 and data B.
- POLL_RD: `av_read`=1, address 3, poll counter incremented.
- POLL_CHK: samples `av_readdata`.
  - bit0=1: go to RES_RD.
  - bit0=0 and counter < `POLL_MAX`: go back to POLL_RD.
  - Otherwise: set the error flag and go to RESP.
- RES_RD: `av_read`=1, address 2. RES_CAP: capture `av_readdata` into the result register.
- RESP:
  - `rsp_valid[id]`=1 with `rsp_data` and `rsp_err` held stable until `rsp_ready[id]`=1.
  - Then clear the error flag and poll counter, and return to IDLE.
- Arbitration is round-robin.
  - The search starts at the index after the last grant; after reset it starts at 0.
  - With several simultaneous requests, the first asserted index in that order wins.
  - Exactly one job is outstanding at a time. Requesters other than g see `req_ready`=0 until the block is back in IDLE.
- `rsp_ready` bits for requesters other than id are ignored. `req_valid` dropping after acceptance has no effect.
- Operands, including 0, are passed through unchecked.

## Timing
- Reset values:
  - All of `req_ready`, `rsp_valid`, `rsp_data`, `rsp_err`, `av_write`, `av_read`, `av_chipselect`, `av_address` and `av_writedata` are 0.
  - `av_byteenable` is 4'hF.
  - The arbiter pointer resets to start at requester 0. State is IDLE.
- Reset mid-job: the job is abandoned and no response is produced. Outputs go to reset values asynchronously.
- Latency, with acceptance at cycle T0:
  - A written at T1, B at T2, first status read at T3, sampled at T4.
  - If done on the first poll: result read at T5, captured at T6, `rsp_valid` at T7.
  - Each extra poll adds 2 cycles.
- Timeout: `rsp_valid` with `rsp_err`=1 appears the cycle after the `POLL_MAX`-th failed POLL_CHK.
- Throughput: with `rsp_ready` already high, the next grant is earliest on the cycle after the RESP handshake, because RESP→IDLE costs 1 cycle.
- Bus strobes are single-cycle and never back-to-back read→read. POLL_CHK always separates reads.

## Structure
- Package `gcd_sched_pkg` holds:
  - The state enum `sched_state_t`.
  - Address constants `GCD_ADDR_A`=0, `GCD_ADDR_B`=1, `GCD_ADDR_RES`=2, `GCD_ADDR_STAT`=3.
  - The constant `GCD_STAT_DONE_BIT`=0.
- Sub-module `rr_arbiter` (parameter N) has:
  - Inputs: `req[N]`, `advance`.
  - Outputs: one-hot `grant[N]` and `grant_id`.
  - Its pointer updates only on `advance`.
- The top level holds the FSM, operand, result and id registers, and the poll counter.

## Test plan
- Bench: `gcd_job_sched` connected to a real `gcd_avalon`.
- Single job: requester 0 submits A=91, B=21.
  - Required: writes at addr0=91, then addr1=21; one or more addr3 polls; one addr2 read.
  - `rsp_valid[0]` asserts with `rsp_data`=7, `rsp_err`=0.
  - If done on the first poll, `rsp_valid[0]` rises 7 cycles after `req_ready[0]`.
- Contention: requesters 0, 1 and 2 all valid at once, with jobs (91,21), (1,1), (2,1023).
  - Required grant order: 0, 1, 2.
  - Required responses: 7, 1, 1, each to the correct `rsp_valid` bit.
- Fairness: requesters 0 and 3 held continuously valid.
  - Required: grants alternate 0, 3, 0, 3.
  - Requester 0 is never granted twice in a row.
- Backpressure: hold `rsp_ready[1]` low for 20 cycles after `rsp_valid[1]`.
  - Required: `rsp_data` stable and no bus activity during the stall.
  - No new grant until the handshake.
- Timeout: a slave model that never sets done, with `POLL_MAX`=4.
  - Required: exactly 4 addr3 reads, no addr2 read.
  - `rsp_err`=1 and `rsp_data`=0.
- Reset mid-poll: assert `reset` during POLL_CHK.
  - Required: all outputs return to reset values immediately and no response is produced.
  - A subsequent job (1,1) completes with result 1.

Source files
------------

// File: rtl/gcd_job_sched_pkg.sv
// Shared types and register map for the GCD job scheduler and its
// Avalon-MM view of the gcd_avalon slave.
package gcd_sched_pkg;
  typedef enum logic [2:0] {
    IDLE, WR_A, WR_B, POLL_RD, POLL_CHK, RES_RD, RES_CAP, RESP
  } sched_state_t;

  localparam logic [1:0] GCD_ADDR_A    = 2'd0;
  localparam logic [1:0] GCD_ADDR_B    = 2'd1;
  localparam logic [1:0] GCD_ADDR_RES  = 2'd2;
  localparam logic [1:0] GCD_ADDR_STAT = 2'd3;
  localparam int GCD_STAT_DONE_BIT     = 0;
endpackage

// File: rtl/gcd_job_sched_if.sv
// Requester-side job/response handshakes plus the Avalon-MM port to the slave.
// master = the scheduler, slave = requesters + gcd_avalon.
interface gcd_job_sched_if #(parameter int NREQ = 4);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0][31:0] req_a;
  logic [NREQ-1:0][31:0] req_b;
  logic [NREQ-1:0]       rsp_valid;
  logic [NREQ-1:0]       rsp_ready;
  logic [31:0]           rsp_data;
  logic                  rsp_err;
  logic [1:0]            av_address;
  logic                  av_write;
  logic                  av_read;
  logic [31:0]           av_writedata;
  logic [31:0]           av_readdata;
  logic [3:0]            av_byteenable;
  logic                  av_chipselect;

  modport master (
    input  req_valid, req_a, req_b, rsp_ready, av_readdata,
    output req_ready, rsp_valid, rsp_data, rsp_err,
           av_address, av_write, av_read, av_writedata, av_byteenable, av_chipselect
  );
  modport slave (
    output req_valid, req_a, req_b, rsp_ready, av_readdata,
    input  req_ready, rsp_valid, rsp_data, rsp_err,
           av_address, av_write, av_read, av_writedata, av_byteenable, av_chipselect
  );
endinterface

// File: rtl/gcd_job_sched_rr_arbiter.sv
// Round-robin arbiter: search starts one past the last grant; the pointer
// only moves when the grant is actually taken (advance).
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_id
);
  logic [IW-1:0] r_ptr;
  logic [IW:0]   w_idx;
  logic          w_found;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    w_found  = 1'b0;
    w_idx    = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = {1'b0, r_ptr} + (IW+1)'(k);
      if (w_idx >= (IW+1)'(N)) w_idx = w_idx - (IW+1)'(N);
      if (!w_found && req[w_idx[IW-1:0]]) begin
        w_found                = 1'b1;
        grant[w_idx[IW-1:0]]   = 1'b1;
        grant_id               = w_idx[IW-1:0];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)        r_ptr <= '0;
    else if (advance) r_ptr <= (grant_id == IW'(N-1)) ? '0 : grant_id + 1'b1;
  end
endmodule

// File: rtl/gcd_job_sched.sv
// Shares one gcd_avalon slave between NREQ requesters: arbitrate, program A/B,
// poll status until done (or POLL_MAX polls), read the result, respond.
module gcd_job_sched
  import gcd_sched_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int POLL_MAX = 1024
) (
  input logic              clock,
  input logic              reset,
  gcd_job_sched_if.master  bus
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(POLL_MAX + 1);

  sched_state_t    r_state;
  logic [NREQ-1:0] w_grant;
  logic [IW-1:0]   w_gid, r_id;
  logic            w_accept;
  logic [31:0]     r_b, r_res, r_av_wdata;
  logic [1:0]      r_av_addr;
  logic            r_av_write, r_av_read, r_err;
  logic [CW-1:0]   r_poll;
  logic [NREQ-1:0] r_rsp_valid;

  // Gated by reset so a requester never sees an acceptance while reset is held.
  assign w_accept = (r_state == IDLE) && (|bus.req_valid) && !reset;

  rr_arbiter #(.N(NREQ)) u_arb (
    .clock    (clock),
    .reset    (reset),
    .req      (bus.req_valid),
    .advance  (w_accept),
    .grant    (w_grant),
    .grant_id (w_gid)
  );

  assign bus.req_ready     = w_accept ? w_grant : '0;
  assign bus.rsp_valid     = r_rsp_valid;
  assign bus.rsp_data      = r_res;
  assign bus.rsp_err       = r_err;
  assign bus.av_address    = r_av_addr;
  assign bus.av_write      = r_av_write;
  assign bus.av_read       = r_av_read;
  assign bus.av_writedata  = r_av_wdata;
  assign bus.av_byteenable = 4'hF;
  assign bus.av_chipselect = r_av_write | r_av_read;

  // Bus strobes are loaded on entry to the state that owns them, so they
  // line up with the state and drop back to 0 by default.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_id        <= '0;
      r_b         <= '0;
      r_res       <= '0;
      r_err       <= 1'b0;
      r_poll      <= '0;
      r_rsp_valid <= '0;
      r_av_addr   <= '0;
      r_av_wdata  <= '0;
      r_av_write  <= 1'b0;
      r_av_read   <= 1'b0;
    end else begin
      r_av_write <= 1'b0;
      r_av_read  <= 1'b0;
      case (r_state)
        IDLE: if (w_accept) begin
          r_id       <= w_gid;
          r_b        <= bus.req_b[w_gid];
          r_av_write <= 1'b1;
          r_av_addr  <= GCD_ADDR_A;
          r_av_wdata <= bus.req_a[w_gid];
          r_state    <= WR_A;
        end
        WR_A: begin
          r_av_write <= 1'b1;
          r_av_addr  <= GCD_ADDR_B;
          r_av_wdata <= r_b;
          r_state    <= WR_B;
        end
        WR_B: begin
          r_av_read <= 1'b1;
          r_av_addr <= GCD_ADDR_STAT;
          r_state   <= POLL_RD;
        end
        POLL_RD: begin
          r_poll  <= r_poll + 1'b1;
          r_state <= POLL_CHK;
        end
        POLL_CHK: begin
          if (bus.av_readdata[GCD_STAT_DONE_BIT]) begin
            r_av_read <= 1'b1;
            r_av_addr <= GCD_ADDR_RES;
            r_state   <= RES_RD;
          end else if (r_poll < CW'(POLL_MAX)) begin
            r_av_read <= 1'b1;
            r_av_addr <= GCD_ADDR_STAT;
            r_state   <= POLL_RD;
          end else begin
            r_err             <= 1'b1;
            r_res             <= '0;
            r_rsp_valid[r_id] <= 1'b1;
            r_state           <= RESP;
          end
        end
        RES_RD: r_state <= RES_CAP;
        RES_CAP: begin
          r_res             <= bus.av_readdata;
          r_rsp_valid[r_id] <= 1'b1;
          r_state           <= RESP;
        end
        RESP: if (bus.rsp_ready[r_id]) begin
          r_rsp_valid <= '0;
          r_err       <= 1'b0;
          r_poll      <= '0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gcd_job_sched.sv
// Directed bench: scheduler against a small gcd_avalon-like slave, plus a
// second instance (POLL_MAX=4) whose slave never reports done.
module tb_gcd_job_sched;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gcd_job_sched_if #(.NREQ(4)) bus ();
  gcd_job_sched_if #(.NREQ(4)) bus_to ();

  gcd_job_sched #(.NREQ(4), .POLL_MAX(1024)) dut    (.clock(clk), .reset(rst), .bus(bus.master));
  gcd_job_sched #(.NREQ(4), .POLL_MAX(4))    dut_to (.clock(clk), .reset(rst), .bus(bus_to.master));

  // ---- slave model: done asserts dly cycles after B is written ----
  function automatic logic [31:0] gcd(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x = a, y = b, t;
    while (y != 0) begin t = x % y; x = y; y = t; end
    return x;
  endfunction

  int          dly = 0;
  int          s_cnt = 0;
  logic [31:0] s_a = '0, s_res = '0;
  logic        s_done = 1'b0;
  always @(posedge clk) begin
    if (bus.av_write) begin
      if (bus.av_address == 2'd0) begin s_a <= bus.av_writedata; s_done <= 1'b0; end
      else if (bus.av_address == 2'd1) begin
        s_res <= gcd(s_a, bus.av_writedata); s_cnt <= dly; s_done <= (dly == 0);
      end
    end else if (!s_done && s_cnt > 0) begin
      s_cnt <= s_cnt - 1;
      if (s_cnt == 1) s_done <= 1'b1;
    end
    bus.av_readdata <= !bus.av_read ? 32'h0 : (bus.av_address == 2'd2) ? s_res :
                       (bus.av_address == 2'd3) ? {31'b0, s_done} : 32'h0;
  end
  assign bus_to.av_readdata = '0;

  // ---- bookkeeping ----
  int nchk = 0, nfail = 0, cyc = 0;
  int gq[$], rid[$];
  logic [31:0] rdat[$], rerr[$], wadr[$], wdat[$];
  int rdn[4], to_rdn[4];
  int acc_cyc = 0, rv_cyc = 0, act = 0, bad_bus = 0, to_nrsp = 0;
  logic [31:0] to_dat, to_err;
  logic prev_rv = 0, prev_rd = 0, prev_trd = 0, to_took = 0;
  logic [3:0] took = '0, hold = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Sample on the falling edge, drive just after the rising edge.
  task automatic step();
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      if (bus.req_ready[i]) begin gq.push_back(i); took[i] = 1'b1; acc_cyc = cyc; end
      if (bus.rsp_valid[i] && bus.rsp_ready[i]) begin
        rid.push_back(i); rdat.push_back(bus.rsp_data); rerr.push_back({31'b0, bus.rsp_err});
      end
    end
    if (|bus.rsp_valid && !prev_rv) rv_cyc = cyc;
    prev_rv = |bus.rsp_valid;
    if (bus.av_write) begin wadr.push_back({30'b0, bus.av_address}); wdat.push_back(bus.av_writedata); end
    if (bus.av_read) rdn[bus.av_address]++;
    if (bus.av_read || bus.av_write) act++;
    if (bus.av_chipselect != (bus.av_read | bus.av_write) || bus.av_byteenable != 4'hF) bad_bus++;
    if (bus.av_read && prev_rd) bad_bus++;
    prev_rd = bus.av_read;
    if (bus_to.req_ready[0]) to_took = 1'b1;
    if (bus_to.av_read) to_rdn[bus_to.av_address]++;
    if (bus_to.av_chipselect != (bus_to.av_read | bus_to.av_write)) bad_bus++;
    if (bus_to.av_read && prev_trd) bad_bus++;
    prev_trd = bus_to.av_read;
    if (bus_to.rsp_valid[0] && bus_to.rsp_ready[0]) begin
      to_nrsp++; to_dat = bus_to.rsp_data; to_err = {31'b0, bus_to.rsp_err};
    end
    cyc++;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++)
      if (took[i]) begin took[i] = 1'b0; if (!hold[i]) bus.req_valid[i] = 1'b0; end
    if (to_took) begin to_took = 1'b0; bus_to.req_valid[0] = 1'b0; end
  endtask

  task automatic clr();
    gq.delete(); rid.delete(); rdat.delete(); rerr.delete(); wadr.delete(); wdat.delete();
    for (int i = 0; i < 4; i++) begin rdn[i] = 0; to_rdn[i] = 0; end
  endtask

  task automatic do_reset();
    bus.req_valid = '0; hold = '0; took = '0;
    rst = 1'b1; step(); step();
    rst = 1'b0; step();
    clr();
  endtask

  task automatic sub(input int i, input logic [31:0] a, input logic [31:0] b);
    bus.req_a[i] = a; bus.req_b[i] = b; bus.req_valid[i] = 1'b1;
  endtask

  task automatic wait_n(input string tag, input int n);
    int k = 0;
    while (rid.size() < n && k < 3000) begin step(); k++; end
    chk(tag, rid.size(), n);
  endtask

  initial begin
    int base_act, base_g, bad;
    rst = 1'b1;
    bus.req_valid = 4'hF; bus.req_a = '0; bus.req_b = '0; bus.rsp_ready = 4'hF;
    bus_to.req_valid = '0; bus_to.req_a = '0; bus_to.req_b = '0; bus_to.rsp_ready = 4'hF;
    step(); step();
    // reset values
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_strobes", {bus.av_write, bus.av_read, bus.av_chipselect}, 0);
    chk("rst_addr", bus.av_address, 0);
    chk("rst_wdata", bus.av_writedata, 0);
    chk("rst_be", bus.av_byteenable, 4'hF);
    chk("rst_rsp", {bus.rsp_err, bus.rsp_data}, 0);
    do_reset();

    // single job, done on first poll
    dly = 0;
    sub(0, 91, 21);
    wait_n("sj_nrsp", 1);
    chk("sj_id", rid[0], 0);
    chk("sj_data", rdat[0], 7);
    chk("sj_err", rerr[0], 0);
    chk("sj_latency", rv_cyc - acc_cyc, 7);
    chk("sj_nwr", wadr.size(), 2);
    chk("sj_wr0", {wadr[0][1:0], wdat[0][29:0]}, {2'd0, 30'd91});
    chk("sj_wr1", {wadr[1][1:0], wdat[1][29:0]}, {2'd1, 30'd21});
    chk("sj_polls", rdn[3], 1);
    chk("sj_resrd", rdn[2], 1);

    // contention
    do_reset(); dly = 3;
    sub(0, 91, 21); sub(1, 1, 1); sub(2, 2, 1023);
    wait_n("ct_nrsp", 3);
    chk("ct_ngrant", gq.size(), 3);
    chk("ct_order", {gq[0][7:0], gq[1][7:0], gq[2][7:0]}, {8'd0, 8'd1, 8'd2});
    chk("ct_ids", {rid[0][7:0], rid[1][7:0], rid[2][7:0]}, {8'd0, 8'd1, 8'd2});
    chk("ct_r0", rdat[0], 7);
    chk("ct_r1", rdat[1], 1);
    chk("ct_r2", rdat[2], 1);

    // fairness
    do_reset(); dly = 1;
    hold = 4'b1001; sub(0, 12, 8); sub(3, 9, 6);
    for (int k = 0; k < 3000 && gq.size() < 4; k++) step();
    hold = '0; bus.req_valid = '0;
    wait_n("fr_nrsp", 4);
    chk("fr_order", {gq[0][3:0], gq[1][3:0], gq[2][3:0], gq[3][3:0]}, 16'h0303);

    // backpressure on requester 1
    do_reset(); dly = 3;
    bus.rsp_ready[1] = 1'b0;
    sub(1, 48, 18);
    for (int k = 0; k < 200 && !bus.rsp_valid[1]; k++) step();
    chk("bp_valid", bus.rsp_valid[1], 1);
    sub(2, 10, 4);
    base_act = act; base_g = gq.size(); bad = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (bus.rsp_data !== 32'd6 || bus.rsp_valid !== 4'b0010) bad++;
    end
    chk("bp_stable", bad, 0);
    chk("bp_no_bus", act - base_act, 0);
    chk("bp_no_grant", gq.size(), base_g);
    bus.rsp_ready[1] = 1'b1;
    wait_n("bp_nrsp", 2);
    chk("bp_r1", {rid[0][3:0], rdat[0][27:0]}, {4'd1, 28'd6});
    chk("bp_r2", {rid[1][3:0], rdat[1][27:0]}, {4'd2, 28'd2});

    // timeout on the never-done instance
    bus_to.req_a[0] = 5; bus_to.req_b[0] = 3; bus_to.req_valid[0] = 1'b1;
    for (int k = 0; k < 200 && to_nrsp == 0; k++) step();
    chk("to_nrsp", to_nrsp, 1);
    chk("to_err", to_err, 1);
    chk("to_data", to_dat, 0);
    chk("to_polls", to_rdn[3], 4);
    chk("to_resrd", to_rdn[2], 0);

    // reset during POLL_CHK
    do_reset(); dly = 50;
    sub(0, 91, 21);
    for (int k = 0; k < 50 && gq.size() == 0; k++) step();
    step(); step(); step();
    chk("mp_polling", rdn[3], 1);
    rst = 1'b1; #1;
    chk("mp_strobes", {bus.av_write, bus.av_read, bus.av_chipselect}, 0);
    chk("mp_addr_wdata", {bus.av_address, bus.av_writedata}, 0);
    chk("mp_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_data}, 0);
    step(); step();
    rst = 1'b0;
    for (int k = 0; k < 80; k++) step();
    chk("mp_no_rsp", rid.size(), 0);
    dly = 0;
    sub(0, 1, 1);
    wait_n("mp_nrsp", 1);
    chk("mp_result", rdat[0], 1);

    chk("bus_protocol", bad_bus, 0);
    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end
endmodule
